mbgd_grad_update: RTL and testbench

- Downstream consumer of the phase-1 hypothesis stage in the mini-batch gradient-descent logistic-regression pipeline.
- Takes each sample's sigmoid output h, its label y and its feature vector x.
- Accumulates the per-feature gradient (h - y)·x_j over a mini-batch of B samples, then updates the coefficient vector theta with saturating arithmetic.
- The updated theta feeds back to the phase-1 stage's teta input.

---
 rtl/mbgd_pkg.sv | 25 ++
 rtl/mbgd_theta_sat_sub.sv | 32 +++
 rtl/mbgd_grad_update.sv | 142 ++++++++++++++
 tb/tb_mbgd_grad_update.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbgd_pkg.sv
// Shared widths, saturation limits and controller states for the
// mini-batch gradient update stage.
package mbgd_pkg;

    localparam int DW         = 8;
    localparam int N          = 8;
    localparam int N_BIT      = 3;
    localparam int B          = 4;
    localparam int B_BIT      = 2;
    localparam int GRAD_SHIFT = 11;

    localparam int ERR_W  = DW + 1;
    localparam int PROD_W = 2 * DW + 1;
    localparam int ACC_W  = PROD_W + B_BIT;

    localparam logic signed [DW-1:0] THETA_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] THETA_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/mbgd_theta_sat_sub.sv
// One coefficient step: theta - (acc >>> GRAD_SHIFT), clamped to the
// signed DW-bit range.
module mbgd_theta_sat_sub
    import mbgd_pkg::*;
(
    input  logic signed [DW-1:0]    i_theta,
    input  logic signed [ACC_W-1:0] i_acc,
    output logic        [DW-1:0]    o_theta
);

    localparam logic signed [ACC_W:0] HI = (ACC_W+1)'(THETA_MAX);
    localparam logic signed [ACC_W:0] LO = (ACC_W+1)'(THETA_MIN);

    logic signed [ACC_W-1:0] w_delta;
    logic signed [ACC_W:0]   w_diff;

    // One guard bit above the accumulator keeps the subtraction exact.
    assign w_delta = i_acc >>> GRAD_SHIFT;
    assign w_diff  = (ACC_W+1)'(i_theta) - (ACC_W+1)'(w_delta);

    // Clamp the exact difference into the coefficient range.
    always_comb begin
        if (w_diff > HI) begin
            o_theta = HI[DW-1:0];
        end else if (w_diff < LO) begin
            o_theta = LO[DW-1:0];
        end else begin
            o_theta = w_diff[DW-1:0];
        end
    end

endmodule

// File: rtl/mbgd_grad_update.sv
// Accumulates (h - y) * x_j over a mini-batch and then rewrites theta one
// coefficient per cycle with a saturating gradient step.
module mbgd_grad_update
    import mbgd_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              theta_load,
    input  logic [DW*N-1:0]   theta_init,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     h,
    input  logic [DW-1:0]     y,
    input  logic [DW*N-1:0]   x,
    output logic [DW*N-1:0]   theta,
    output logic              update_done,
    output logic [B_BIT-1:0]  batch_cnt
);

    state_t                   r_state;
    state_t                   w_next_state;
    logic [N-1:0][DW-1:0]     r_theta;
    logic signed [ACC_W-1:0]  r_acc [N];
    logic [N_BIT-1:0]         r_k;
    logic [B_BIT-1:0]         r_batch_cnt;
    logic                     r_update_done;

    logic                     w_in_ready;
    logic                     w_accept;
    logic                     w_last_sample;
    logic                     w_last_k;
    logic signed [ERR_W-1:0]  w_err;
    logic signed [PROD_W-1:0] w_prod [N];
    logic [DW-1:0]            w_theta_new;

    // h and y are unsigned, so the error needs one extra sign bit.
    assign w_err = $signed({1'b0, h}) - $signed({1'b0, y});

    for (genvar j = 0; j < N; j++) begin : g_prod
        assign w_prod[j] = PROD_W'(w_err) * PROD_W'($signed(x[DW*j +: DW]));
    end

    assign w_accept      = in_valid && w_in_ready;
    assign w_last_sample = (r_batch_cnt == B_BIT'(B-1));
    assign w_last_k      = (r_k == N_BIT'(N-1));

    mbgd_theta_sat_sub u_sat (
        .i_theta (r_theta[r_k]),
        .i_acc   (r_acc[r_k]),
        .o_theta (w_theta_new)
    );

    // Controller state register; a load aborts any batch in progress.
    always_ff @(posedge clk) begin
        if (resetn) begin
            r_state <= ACCUM;
        end else if (theta_load) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ACCUM, DONE: begin
                if (w_accept && w_last_sample) begin
                    w_next_state = UPDATE;
                end else begin
                    w_next_state = ACCUM;
                end
            end
            UPDATE: begin
                if (w_last_k) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = UPDATE;
                end
            end
            default: w_next_state = ACCUM;
        endcase
    end

    // Ready decode; a pending load or reset blocks acceptance combinationally.
    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            ACCUM, DONE: w_in_ready = !resetn && !theta_load;
            UPDATE:      w_in_ready = 1'b0;
            default:     w_in_ready = 1'b0;
        endcase
    end

    // Accumulators, coefficient write-back, batch and index counters.
    always_ff @(posedge clk) begin
        if (resetn) begin
            r_theta       <= '0;
            r_k           <= '0;
            r_batch_cnt   <= '0;
            r_update_done <= 1'b0;
            for (int j = 0; j < N; j++) begin
                r_acc[j] <= '0;
            end
        end else if (theta_load) begin
            r_theta       <= theta_init;
            r_k           <= '0;
            r_batch_cnt   <= '0;
            r_update_done <= 1'b0;
            for (int j = 0; j < N; j++) begin
                r_acc[j] <= '0;
            end
        end else begin
            r_update_done <= 1'b0;
            if (r_state == UPDATE) begin
                r_theta[r_k] <= w_theta_new;
                r_acc[r_k]   <= '0;
                if (w_last_k) begin
                    r_k           <= '0;
                    r_update_done <= 1'b1;
                end else begin
                    r_k <= r_k + N_BIT'(1);
                end
            end else if (w_accept) begin
                for (int j = 0; j < N; j++) begin
                    r_acc[j] <= r_acc[j] + ACC_W'(w_prod[j]);
                end
                // B is a power of two, so the counter wraps to 0 on the B-th sample.
                r_batch_cnt <= r_batch_cnt + B_BIT'(1);
            end else begin
                r_batch_cnt <= r_batch_cnt;
            end
        end
    end

    assign theta       = r_theta;
    assign update_done = r_update_done;
    assign batch_cnt   = r_batch_cnt;
    assign in_ready    = w_in_ready;

endmodule

// File: tb/tb_mbgd_grad_update.sv
// Self-checking bench for mbgd_grad_update: fixed batch vectors, hand-built
// corner sequences and random traffic against a batch-level reference model.
module tb_mbgd_grad_update;

    localparam int DW    = 8;
    localparam int N     = 8;
    localparam int B     = 4;
    localparam int B_BIT = 2;

    logic              clk = 1'b0;
    logic              resetn;
    logic              theta_load;
    logic [DW*N-1:0]   theta_init;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     h;
    logic [DW-1:0]     y;
    logic [DW*N-1:0]   x;
    logic [DW*N-1:0]   theta;
    logic              update_done;
    logic [B_BIT-1:0]  batch_cnt;

    always #5 clk = ~clk;

    mbgd_grad_update dut (
        .clk         (clk),
        .resetn      (resetn),
        .theta_load  (theta_load),
        .theta_init  (theta_init),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .h           (h),
        .y           (y),
        .x           (x),
        .theta       (theta),
        .update_done (update_done),
        .batch_cnt   (batch_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: coefficients, pending batch, update schedule.
    int              m_theta [N];
    int              m_new   [N];
    int              m_phase;
    bit              m_done;
    int              bh [$];
    int              by [$];
    logic [DW*N-1:0] bx [$];
    bit              m_accepted;
    logic            dut_ready;

    typedef struct {
        logic [DW*N-1:0] init;
        logic [DW-1:0]   hv;
        logic [DW-1:0]   yv;
        logic [DW*N-1:0] xv;
        logic [DW*N-1:0] expv;
    } vec_t;

    vec_t tbl [6];

    function automatic logic [DW*N-1:0] rep(input logic [DW-1:0] b);
        logic [DW*N-1:0] r;
        for (int j = 0; j < N; j++) r[DW*j +: DW] = b;
        return r;
    endfunction

    function automatic int xs(input logic [DW*N-1:0] v, input int j);
        return int'($signed(v[DW*j +: DW]));
    endfunction

    function automatic logic [DW*N-1:0] m_pack();
        logic [DW*N-1:0] p;
        for (int j = 0; j < N; j++) p[DW*j +: DW] = m_theta[j][DW-1:0];
        return p;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Whole-batch gradient from the definition: sum of (h-y)*x_j, floor-scaled.
    task automatic finish_batch();
        for (int j = 0; j < N; j++) begin
            int s = 0;
            int nv;
            for (int i = 0; i < B; i++) s += (bh[i] - by[i]) * xs(bx[i], j);
            nv = m_theta[j] - (s >>> 11);
            if (nv > 127)  nv = 127;
            if (nv < -128) nv = -128;
            m_new[j] = nv;
        end
        bh.delete(); by.delete(); bx.delete();
        m_phase = 1;
    endtask

    task automatic model_clear();
        bh.delete(); by.delete(); bx.delete();
        m_phase = 0;
        m_done  = 1'b0;
    endtask

    // One clock cycle: check ready, advance DUT and model, check outputs.
    task automatic step();
        bit pred_ready;
        #1;
        pred_ready = !resetn && !theta_load && (m_phase == 0);
        dut_ready  = in_ready;
        chk("in_ready", 64'(in_ready), 64'(pred_ready));
        m_accepted = in_valid && pred_ready;
        @(posedge clk);
        if (resetn) begin
            for (int j = 0; j < N; j++) m_theta[j] = 0;
            model_clear();
        end else if (theta_load) begin
            for (int j = 0; j < N; j++) m_theta[j] = xs(theta_init, j);
            model_clear();
        end else begin
            m_done = 1'b0;
            if (m_phase > 0) begin
                m_theta[m_phase-1] = m_new[m_phase-1];
                if (m_phase == N) begin
                    m_phase = 0;
                    m_done  = 1'b1;
                end else begin
                    m_phase++;
                end
            end
            if (m_accepted) begin
                bh.push_back(int'(h)); by.push_back(int'(y)); bx.push_back(x);
                if (bh.size() == B) finish_batch();
            end
        end
        #1;
        chk("update_done", 64'(update_done), 64'(m_done));
        chk("theta", theta, m_pack());
        chk("batch_cnt", 64'(batch_cnt), 64'(bh.size()));
    endtask

    task automatic do_load(input logic [DW*N-1:0] v);
        theta_load = 1'b1;
        theta_init = v;
        step();
        theta_load = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] hv, input logic [DW-1:0] yv, input logic [DW*N-1:0] xv);
        int tries = 0;
        in_valid = 1'b1; h = hv; y = yv; x = xv;
        do begin
            step();
            tries++;
        end while (!m_accepted && tries < 50);
        if (!m_accepted) begin
            checks++; errors++;
            $display("FAIL send_timeout actual=not_accepted expected=accepted at %0t", $time);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int lat, low_cnt, acc_n, dcount;
        logic [DW*N-1:0] lb;

        resetn = 1'b1; theta_load = 1'b0; theta_init = '0;
        in_valid = 1'b0; h = '0; y = '0; x = '0;
        for (int j = 0; j < N; j++) m_theta[j] = 0;
        model_clear();
        m_accepted = 1'b0;

        step(); step();
        resetn = 1'b0;
        chk("reset_theta", theta, 64'd0);
        chk("reset_cnt", 64'(batch_cnt), 64'd0);
        step();

        tbl[0] = '{rep(8'd0),    8'd200, 8'd0,   rep(8'd64),  rep(8'hE7)};
        tbl[1] = '{rep(8'd100),  8'd0,   8'd255, rep(8'd127), rep(8'h7F)};
        tbl[2] = '{rep(8'h9C),   8'd0,   8'd255, rep(8'h80),  rep(8'h80)};
        tbl[3] = '{64'd0,        8'd128, 8'd128, {$urandom, $urandom}, 64'd0};
        for (int j = 0; j < N; j++) tbl[3].init[DW*j +: DW] = DW'(j);
        tbl[3].expv = tbl[3].init;
        tbl[4] = '{rep(8'd0),    8'd255, 8'd0,   rep(8'hFF),  rep(8'h01)};
        tbl[5] = '{rep(8'd0),    8'd1,   8'd0,   rep(8'h01),  rep(8'h00)};

        foreach (tbl[i]) begin
            do_load(tbl[i].init);
            for (int s = 0; s < B; s++) send(tbl[i].hv, tbl[i].yv, tbl[i].xv);
            lat = 0;
            while (update_done !== 1'b1 && lat < 3*N) begin
                step();
                lat++;
            end
            chk("done_latency", 64'(lat), 64'(N));
            chk("table_theta", theta, tbl[i].expv);
            step(); step();
        end

        // Continuous in_valid across a batch boundary.
        do_load({$urandom, $urandom});
        in_valid = 1'b1; h = DW'($urandom); y = DW'($urandom); x = {$urandom, $urandom};
        acc_n = 0; low_cnt = 0;
        for (int c = 0; c < 60 && acc_n < B + 1; c++) begin
            step();
            if (dut_ready === 1'b0) low_cnt++;
            if (m_accepted) begin
                acc_n++;
                h = DW'($urandom); y = DW'($urandom); x = {$urandom, $urandom};
            end
        end
        in_valid = 1'b0;
        chk("chain_accepts", 64'(acc_n), 64'(B + 1));
        chk("chain_ready_low", 64'(low_cnt), 64'(N));
        chk("chain_batch_cnt", 64'(batch_cnt), 64'd1);

        // Load collides with the second sample of a batch.
        do_load(rep(8'd3));
        send(8'd50, 8'd0, rep(8'd20));
        lb = {$urandom, $urandom};
        in_valid = 1'b1; theta_load = 1'b1; theta_init = lb;
        step();
        chk("load_blocks_ready", 64'(dut_ready), 64'd0);
        theta_load = 1'b0; in_valid = 1'b0;
        chk("load_cnt", 64'(batch_cnt), 64'd0);
        chk("load_theta", theta, lb);
        step();

        // Reset in the middle of the coefficient sweep (k = 3).
        do_load(rep(8'd10));
        for (int s = 0; s < B; s++) send(8'd200, 8'd0, rep(8'd64));
        step(); step(); step();
        resetn = 1'b1;
        step();
        resetn = 1'b0;
        chk("midreset_theta", theta, 64'd0);
        dcount = 0;
        for (int c = 0; c < N + 2; c++) begin
            step();
            if (update_done === 1'b1) dcount++;
        end
        chk("midreset_no_done", 64'(dcount), 64'd0);

        // Random traffic with occasional loads.
        for (int r = 0; r < 8; r++) begin
            do_load({$urandom, $urandom});
            for (int c = 0; c < 60; c++) begin
                in_valid   = 1'($urandom_range(0, 1));
                theta_load = ($urandom_range(0, 39) == 0);
                theta_init = {$urandom, $urandom};
                h = DW'($urandom);
                y = ($urandom_range(0, 1) == 1) ? DW'($urandom) : (($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0);
                x = {$urandom, $urandom};
                step();
            end
            theta_load = 1'b0;
            in_valid   = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
